// File: rtl/sensor_seq_pkg.sv
// Shared types and constants for the sensor power-up reset sequencer.
// State encodings are fixed because seq_state is exported for debug.
package sensor_seq_pkg;

  typedef enum logic [2:0] {
    S_SENSOR_RST = 3'd0,
    S_I2C_WAIT   = 3'd1,
    S_CONFIG     = 3'd2,
    S_DONE       = 3'd3,
    S_FAIL       = 3'd4
  } seq_state_e;

  localparam int unsigned CNT_W_DEF   = 25;

  localparam int unsigned HB_W        = 29;
  localparam int unsigned HB_DONE_BIT = 28;
  localparam int unsigned HB_FAIL_BIT = 25;
  localparam int unsigned HB_RUN_BIT  = 27;

endpackage

// File: rtl/seq_delay_cnt.sv
// Clearable up-counter with an equality expire flag against a compare value.
// Used for both the main state delay and the CrossLink release delay.
module seq_delay_cnt #(
  parameter int unsigned W = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] cmp,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over count; otherwise advance while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == cmp);

endmodule

// File: rtl/sensor_reset_seq.sv
// Supervised power-up reset sequencer for sensor, I2C engine and CrossLink.
// Optional heartbeat output enabled by defining SENSOR_SEQ_HEARTBEAT_EN.
module sensor_reset_seq
  import sensor_seq_pkg::*;
#(
  parameter int unsigned SENSOR_RST_CYC  = 8388608,
  parameter int unsigned I2C_DLY_CYC     = 1024,
  parameter int unsigned XLINK_DLY_CYC   = 65536,
  parameter int unsigned CFG_TIMEOUT_CYC = 16777216,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst_req,
  input  logic       config_done,
  output logic       reset_sensor,
  output logic       i2c_rst_n,
  output logic       reset_crosslink,
  output logic       seq_done,
  output logic       seq_fail,
  output logic [2:0] retry_cnt,
  output logic [2:0] seq_state,
  output logic       hb
);

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

  seq_state_e state_q, state_d;
  logic [2:0] retry_q, retry_d;
  logic       rs_q, rs_d;
  logic       i2c_q, i2c_d;
  logic       xl_q, xl_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;

  logic             m_clr, m_en, m_hit, m_exp;
  logic [CNT_W-1:0] m_cmp;
  logic             x_clr, x_en, x_hit;

  // Per-state delay selection for the main counter
  always_comb begin
    m_cmp = '0;
    m_en  = 1'b0;
    case (state_q)
      S_SENSOR_RST: begin
        m_cmp = CNT_W'(SENSOR_RST_CYC - 1);
        m_en  = 1'b1;
      end
      S_I2C_WAIT: begin
        m_cmp = CNT_W'(I2C_DLY_CYC - 1);
        m_en  = 1'b1;
      end
      S_CONFIG: begin
        m_cmp = CNT_W'(CFG_TIMEOUT_CYC - 1);
        m_en  = 1'b1;
      end
      default: begin
        m_cmp = '0;
        m_en  = 1'b0;
      end
    endcase
  end

  assign m_exp = m_hit & m_en;

  // Next state, retry bookkeeping and registered output values
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (soft_rst_req) begin
      state_d = S_SENSOR_RST;
      retry_d = '0;
    end else begin
      case (state_q)
        S_SENSOR_RST: if (m_exp) state_d = S_I2C_WAIT;
        S_I2C_WAIT:   if (m_exp) state_d = S_CONFIG;
        S_CONFIG: begin
          if (config_done && xl_q) begin
            state_d = S_DONE;
          end else if (m_exp) begin
            if (retry_q < MAX_R) begin
              retry_d = retry_q + 3'd1;
              state_d = S_SENSOR_RST;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        S_DONE: state_d = S_DONE;
        S_FAIL: state_d = S_FAIL;
        default: state_d = S_SENSOR_RST;
      endcase
    end

    rs_d   = (state_d == S_I2C_WAIT) ||
             (state_d == S_CONFIG) ||
             (state_d == S_DONE);
    i2c_d  = (state_d == S_CONFIG) ||
             (state_d == S_DONE);
    done_d = (state_d == S_DONE);
    fail_d = (state_d == S_FAIL);
    xl_d   = rs_d & (xl_q | (x_en & x_hit));
  end

  // Main counter restarts on every state entry or soft restart
  assign m_clr = soft_rst_req | (state_d != state_q);

  // CrossLink counter runs from sensor release until it fires
  assign x_clr = ~rs_d;
  assign x_en  = rs_q & ~xl_q;

  seq_delay_cnt #(.W(CNT_W)) u_main_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (m_clr),
    .en     (m_en),
    .cmp    (m_cmp),
    .expire (m_hit)
  );

  seq_delay_cnt #(.W(CNT_W)) u_xlink_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (x_clr),
    .en     (x_en),
    .cmp    (CNT_W'(XLINK_DLY_CYC - 1)),
    .expire (x_hit)
  );

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SENSOR_RST;
      retry_q <= '0;
      rs_q    <= 1'b0;
      i2c_q   <= 1'b0;
      xl_q    <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      rs_q    <= rs_d;
      i2c_q   <= i2c_d;
      xl_q    <= xl_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign reset_sensor    = rs_q;
  assign i2c_rst_n       = i2c_q;
  assign reset_crosslink = xl_q;
  assign seq_done        = done_q;
  assign seq_fail        = fail_q;
  assign retry_cnt       = retry_q;
  assign seq_state       = state_q;

`ifdef SENSOR_SEQ_HEARTBEAT_EN
  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic            hb_q, hb_d;

  // Free-running blink counter with state-dependent rate select
  always_comb begin
    hb_cnt_d = hb_cnt_q + HB_W'(1);
    hb_d     = hb_cnt_d[HB_RUN_BIT];
    if (state_d == S_DONE) begin
      hb_d = hb_cnt_d[HB_DONE_BIT];
    end else if (state_d == S_FAIL) begin
      hb_d = hb_cnt_d[HB_FAIL_BIT];
    end
  end

  // Heartbeat registers, cleared only by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign hb = hb_q;
`else
  assign hb = 1'b0;
`endif

endmodule
